// File: rtl/cbus_arbiter.sv
// Round-robin arbiter granting the shared memory-side cache bus to one refill/writeback
// master for a whole burst, with response steering and burst-length checking.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int SEL_BITS = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t  [NUM_REQ-1:0]   ireqs,
  output cbus_resp_t [NUM_REQ-1:0]   iresps,
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic                       busy,
  output logic [SEL_BITS-1:0]        grant_idx,
  output logic                       len_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [4:0]          beat_cnt_q, beat_cnt_d;
  logic [3:0]          len_q, len_d;
  logic                len_err_q, len_err_d;

  logic                found_s;
  logic [SEL_BITS-1:0] win_s;
  logic [SEL_BITS:0]   cand_s;
  logic [SEL_BITS-1:0] idx_s;

  // Scan from ptr upward with wrap; one extra bit keeps ptr+k from overflowing before the modulo.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
      if (cand_s >= (SEL_BITS+1)'(NUM_REQ)) begin
        cand_s = cand_s - (SEL_BITS+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      idx_s = cand_s[SEL_BITS-1:0];
      if (!found_s && ireqs[idx_s].valid) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = BUSY;
          sel_d      = win_s;
          len_d      = ireqs[win_s].len;
          beat_cnt_d = 5'd0;
          ptr_d      = (win_s == SEL_BITS'(NUM_REQ-1)) ? '0 : win_s + SEL_BITS'(1);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (oresp.ready) begin
          beat_cnt_d = (beat_cnt_q != 5'd31) ? beat_cnt_q + 5'd1 : beat_cnt_q;
          if (oresp.last) begin
            state_d = IDLE;
            // beat_cnt_q counts beats before this last one, matching the beats-1 len encoding.
            if (beat_cnt_q != {1'b0, len_q}) begin
              len_err_d = 1'b1;
            end else begin
              len_err_d = len_err_q;
            end
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= 5'd0;
      len_q      <= 4'd0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
    end
  end

  // Request and response paths are combinational so write data and read beats pass with no delay.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == BUSY) begin
      oreq          = ireqs[sel_q];
      iresps[sel_q] = oresp;
    end else begin
      oreq   = '0;
      iresps = '0;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = sel_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: scenario tasks plus a response scoreboard that
// records each driven bridge beat and pops it when the granted requester should see it.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              reset;
  cbus_req_t  [N-1:0] ireqs;
  cbus_resp_t [N-1:0] iresps;
  cbus_req_t         oreq;
  cbus_resp_t        oresp;
  logic              busy;
  logic [0:0]        grant_idx;
  logic              len_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [0:0]  idx;
    logic        last;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];
  sb_t e;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [0:0] i, input logic v, input logic w,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] len);
    cbus_req_t r;
    r.valid    = v;
    r.is_write = w;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = w ? 4'hF : 4'h0;
    r.data     = data;
    r.len      = len;
    ireqs[i]   = r;
  endtask

  // Drive one accepted bridge beat and record where it must appear.
  task automatic drive_beat(input logic [0:0] idx, input logic [31:0] d, input logic lst);
    sb_t s;
    oresp.ready = 1'b1;
    oresp.last  = lst;
    oresp.data  = d;
    s.idx  = idx;
    s.last = lst;
    s.data = d;
    sb_q.push_back(s);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'd0);
    tick();
    total++;
    if (busy !== 1'b0 || oreq !== '0 || iresps !== '0) begin
      bad++;
      $display("FAIL reset_hold: busy=%0b oreq.valid=%0b, required busy=0 oreq.valid=0", busy, oreq.valid);
    end
    ireqs = '0;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || grant_idx !== 1'b0 || len_err !== 1'b0 || oreq !== '0 || iresps !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b grant=%0d len_err=%0b, required 0 0 0", busy, grant_idx, len_err);
    end
  endtask

  task automatic test_single_read();
    tick();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'd15);
    #1;
    total++;
    if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_latency: busy=%0b oreq.valid=%0b in request cycle, required 0 0", busy, oreq.valid);
    end
    tick();
    total++;
    if (busy !== 1'b1 || oreq.valid !== 1'b1 || grant_idx !== 1'b0 || oreq.addr !== 32'h0000_1000) begin
      bad++;
      $display("FAIL rd_grant: busy=%0b valid=%0b grant=%0d addr=%h, required 1 1 0 00001000",
               busy, oreq.valid, grant_idx, oreq.addr);
    end
    for (int b = 0; b < 16; b++) begin
      drive_beat(1'b0, 32'hA000_0000 + 32'(b), b == 15);
      #1;
      e = sb_q.pop_front();
      total++;
      if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
        bad++;
        $display("FAIL rd_beat: port%0d resp=%h other=%h, required %h other=0",
                 e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
      end
      tick();
    end
    ireqs = '0;
    oresp = '0;
    #1;
    total++;
    if (busy !== 1'b0 || oreq !== '0 || iresps !== '0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_end: busy=%0b valid=%0b len_err=%0b, required 0 0 0", busy, oreq.valid, len_err);
    end
  endtask

  task automatic test_dcache_write();
    set_req(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'hD000_0000, 4'd3);
    tick();
    total++;
    if (busy !== 1'b1 || grant_idx !== 1'b1 || oreq.is_write !== 1'b1) begin
      bad++;
      $display("FAIL wr_grant: busy=%0b grant=%0d is_write=%0b, required 1 1 1", busy, grant_idx, oreq.is_write);
    end
    for (int b = 0; b < 4; b++) begin
      ireqs[1].data = 32'hD000_0000 + 32'(b);
      drive_beat(1'b1, 32'hB000_0000 + 32'(b), b == 3);
      #1;
      e = sb_q.pop_front();
      total++;
      if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
        bad++;
        $display("FAIL wr_beat: port%0d resp=%h other=%h, required %h other=0",
                 e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
      end
      total++;
      if (oreq.data !== 32'hD000_0000 + 32'(b) || oreq.valid !== 1'b1) begin
        bad++;
        $display("FAIL wr_data: oreq.data=%h valid=%0b, required %h 1", oreq.data, oreq.valid, 32'hD000_0000 + 32'(b));
      end
      tick();
    end
    ireqs = '0;
    oresp = '0;
    #1;
    total++;
    if (busy !== 1'b0 || grant_idx !== 1'b1 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_end: busy=%0b grant=%0d len_err=%0b, required 0 1 0", busy, grant_idx, len_err);
    end
  endtask

  task automatic test_simultaneous();
    logic [0:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_a = '{32'h100, 32'h200, 32'h100, 32'h200};
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'd0);
    for (int g = 0; g < 4; g++) begin
      tick();
      total++;
      if (busy !== 1'b1 || grant_idx !== exp_g[g] || oreq.addr !== exp_a[g]) begin
        bad++;
        $display("FAIL rr_grant%0d: busy=%0b grant=%0d addr=%h, required 1 %0d %h",
                 g, busy, grant_idx, oreq.addr, exp_g[g], exp_a[g]);
      end
      drive_beat(exp_g[g], 32'hC000_0000 + 32'(g), 1'b1);
      #1;
      e = sb_q.pop_front();
      total++;
      if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
        bad++;
        $display("FAIL rr_beat%0d: port%0d resp=%h other=%h, required %h other=0",
                 g, e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
      end
      tick();
      // The winner drops valid after last; after the second burst both re-request together.
      if (g == 1) begin
        set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'd0);
      end else begin
        ireqs[exp_g[g]].valid = 1'b0;
      end
      oresp = '0;
      #1;
      total++;
      if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
        bad++;
        $display("FAIL rr_bubble%0d: busy=%0b valid=%0b, required 0 0", g, busy, oreq.valid);
      end
    end
    ireqs = '0;
  endtask

  task automatic test_stray();
    for (int k = 0; k < 3; k++) begin
      oresp.ready = 1'b1;
      oresp.last  = (k == 1);
      oresp.data  = 32'h5555_0000 + 32'(k);
      #1;
      total++;
      if (iresps !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL stray_resp%0d: iresps=%h busy=%0b, required 0 0", k, iresps, busy);
      end
      tick();
    end
    oresp = '0;
    #1;
    total++;
    if (len_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_len_err: len_err=%0b busy=%0b, required 0 0", len_err, busy);
    end
  endtask

  task automatic test_len_mismatch();
    logic [3:0] lens [2];
    int         beats [2];
    lens  = '{4'd3, 4'd1};
    beats = '{2, 2};
    for (int r = 0; r < 2; r++) begin
      set_req(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, lens[r]);
      tick();
      for (int b = 0; b < beats[r]; b++) begin
        drive_beat(1'b0, 32'hE000_0000 + 32'(r * 16 + b), b == beats[r] - 1);
        #1;
        e = sb_q.pop_front();
        total++;
        if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
          bad++;
          $display("FAIL len_beat: port%0d resp=%h other=%h, required %h other=0",
                   e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
        end
        tick();
      end
      ireqs = '0;
      oresp = '0;
      #1;
      total++;
      if (len_err !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL len_err_burst%0d: len_err=%0b busy=%0b, required 1 0", r, len_err, busy);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    set_req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'd15);
    tick();
    for (int b = 0; b < 5; b++) begin
      drive_beat(1'b0, 32'hF000_0000 + 32'(b), 1'b0);
      #1;
      e = sb_q.pop_front();
      total++;
      if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
        bad++;
        $display("FAIL rst_beat: port%0d resp=%h other=%h, required %h other=0",
                 e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
      end
      tick();
    end
    reset       = 1'b1;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hF000_0005;
    #1;
    total++;
    if (oreq.valid !== 1'b0 || busy !== 1'b0 || iresps !== '0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: valid=%0b busy=%0b iresps=%h len_err=%0b, required 0 0 0 0",
               oreq.valid, busy, iresps, len_err);
    end
    ireqs = '0;
    oresp = '0;
    tick();
    reset = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'd0);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: busy=%0b, required 0", busy);
    end
    tick();
    total++;
    if (busy !== 1'b1 || grant_idx !== 1'b1 || oreq.addr !== 32'h500) begin
      bad++;
      $display("FAIL rst_regrant: busy=%0b grant=%0d addr=%h, required 1 1 00000500", busy, grant_idx, oreq.addr);
    end
    drive_beat(1'b1, 32'h0000_0077, 1'b1);
    #1;
    e = sb_q.pop_front();
    total++;
    if (iresps[e.idx] !== {1'b1, e.last, e.data} || iresps[~e.idx] !== '0) begin
      bad++;
      $display("FAIL rst_beat_after: port%0d resp=%h other=%h, required %h other=0",
               e.idx, iresps[e.idx], iresps[~e.idx], {1'b1, e.last, e.data});
    end
    tick();
    ireqs = '0;
    oresp = '0;
    #1;
    total++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_final: busy=%0b len_err=%0b, required 0 0", busy, len_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    ireqs = '0;
    oresp = '0;
    test_reset();
    test_single_read();
    test_dcache_write();
    test_simultaneous();
    test_stray();
    test_len_mismatch();
    test_reset_mid_burst();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
